binary_add_6_opload: RTL and testbench
======================================

# binary_add_6_opload

Operand loader that sits directly upstream of the 6-bit registered ripple adder. It accepts operand words one at a time over a valid/ready input stream, pairs them as A then B, and presents both on stable registered buses. It pulses the adder's enable for exactly one cycle, then asserts `done` in the cycle the adder's registered sum is valid. An optional carry-out flag supplies the carry that the adder itself discards.

## Interface
- `W`, default 6: operand width; must match the adder width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` carries an operand word.
- `in_ready` output 1: loader accepts a word this cycle.
- `in_data` input W: operand word; the first word of a pair is A, the second is B.
- `A` output W: registered operand A, drives adder `A`.
- `B` output W: registered operand B, drives adder `B`.
- `en` output 1: adder enable, one-cycle pulse per operand pair.
- `done` output 1: one-cycle pulse; the adder's `S` holds A+B (mod 2^W) this cycle.
- `ops_cnt` output 8: count of completed operations.
- `carry` output 1: carry-out of A+B; only present with `OPLOAD_CARRY_EN`.

## Operation
- FSM states: IDLE, LOAD_B, ISSUE, WAIT. The state register is 2 bits.
- A word transfers on any edge where `in_valid && in_ready`.
- IDLE:
  - `in_ready`=1.
  - On a transfer: A <= `in_data`, then go to LOAD_B.
  - With no transfer: stay in IDLE.
- LOAD_B:
  - `in_ready`=1.
  - On a transfer: B <= `in_data`, then go to ISSUE.
  - With no transfer: stay in LOAD_B; A is held.
- ISSUE:
  - `in_ready`=0 and `en`=1.
  - Always go to WAIT.
  - The adder captures A+B on the edge that leaves ISSUE.
- WAIT:
  - `in_ready`=0, `en`=0, `done`=1.
  - `ops_cnt` increments on the edge leaving WAIT; it wraps 255 -> 0.
  - Always go to IDLE.
- `in_ready`, `en` and `done` are pure decodes of the state register. There is no combinational path from `in_valid` or `in_data` to any output.
- A and B change only on their own capture. They stay stable through ISSUE and WAIT and until the next capture.
- Width rule: the sum is mod 2^W. The loader never alters the data.
- `in_valid` high while `in_ready`=0 is ignored; the word is not consumed and the source must hold it.
- Reset values (asserted asynchronously, independent of `clk`):
  - State: IDLE.
  - A=0, B=0, `ops_cnt`=0.
  - `en`=0, `done`=0, `carry`=0.
  - `in_ready`=1, as decoded from IDLE.
- Reset mid-operation (in LOAD_B, ISSUE or WAIT):
  - Any partial pair is discarded.
  - No `done` is issued for it and `ops_cnt` does not increment.
  - If `en` was high, it falls immediately.

## Timing
- Minimum 4 cycles per operation: transfer of A, transfer of B, ISSUE, WAIT.
- Back-to-back: the next A can transfer in the cycle after WAIT.
- `en` is high exactly one cycle per pair; `done` is high exactly the following cycle.
- Latency from the B-transfer edge: `en` is high in cycle +1 and `done` in cycle +2, relative to that edge.
- Stall between A and B: any number of idle cycles in LOAD_B is allowed; the pairing is preserved.

## Configuration
- `OPLOAD_CARRY_EN` defined:
  - Add the `carry` output, a register loaded on the edge leaving ISSUE with bit W of the (W+1)-bit sum {1'b0,A}+{1'b0,B}.
  - `carry` is valid while `done`=1 and is held until the next ISSUE.
  - Reset value is 0.
- `OPLOAD_CARRY_EN` undefined: the `carry` port and its register are absent; all other behaviour is identical.

## Test plan
- Reset, then A=6'd5, B=6'd9 with `in_valid` held high: `en` high in exactly one cycle, `done` high in the next; adder S=14; `ops_cnt`=1 after WAIT; `carry`=0.
- A=6'd40, B=6'd30: S=6'd6; with `OPLOAD_CARRY_EN`, `carry`=1 during `done`.
- A transferred, then `in_valid` low for 7 cycles, then B=6'd1 with A=6'd2: stays in LOAD_B, `in_ready`=1 throughout the gap; then S=3.
- `in_valid` held high with new data during ISSUE/WAIT: no transfer (`in_ready`=0); A and B unchanged until the next IDLE capture.
- `rst` pulsed mid-cycle while in ISSUE: `en` drops immediately; A=B=0, `ops_cnt` unchanged, no `done`; the next pair completes normally.
- 256 back-to-back operations: `ops_cnt` wraps to 0; exactly 4 cycles per operation.

Source files
------------

// File: rtl/binary_add_6_opload_if.sv
// Operand-loader bus: upstream valid/ready word stream plus the registered
// operand/enable/done outputs toward the adder. OPLOAD_CARRY_EN adds the carry wire.
interface binary_add_6_opload_if #(
  parameter int W = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         en;
  logic         done;
  logic [7:0]   ops_cnt;
`ifdef OPLOAD_CARRY_EN
  logic         carry;

  modport master (
    output in_valid, in_data,
    input  in_ready, A, B, en, done, ops_cnt, carry
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, A, B, en, done, ops_cnt, carry
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready, A, B, en, done, ops_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, A, B, en, done, ops_cnt
  );
`endif
endinterface

// File: rtl/binary_add_6_opload.sv
// Operand loader for the registered ripple adder: pairs two stream words as A/B,
// pulses en, then done. Optional carry-out register under OPLOAD_CARRY_EN.
module binary_add_6_opload #(
  parameter int W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  binary_add_6_opload_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  function automatic logic add_carry(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W];
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [7:0]   ops_cnt_q, ops_cnt_d;
  logic         in_ready_q, in_ready_d;
  logic         en_q, en_d;
  logic         done_q, done_d;
  logic         xfer_s;

  // Handshake flags are flopped decodes of the next state, so they equal a
  // decode of state_q at all times and never see in_valid/in_data combinationally.
  assign xfer_s = bus.in_valid && in_ready_q;

  // Next-state, operand capture and counter logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ops_cnt_d = ops_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          a_d     = bus.in_data;
          state_d = LOAD_B;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_B: begin
        if (xfer_s) begin
          b_d     = bus.in_data;
          state_d = ISSUE;
        end else begin
          state_d = LOAD_B;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        ops_cnt_d = ops_cnt_q + 8'd1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flag decode of the upcoming state
  always_comb begin
    in_ready_d = 1'b0;
    en_d       = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      IDLE:    in_ready_d = 1'b1;
      LOAD_B:  in_ready_d = 1'b1;
      ISSUE:   en_d       = 1'b1;
      WAIT:    done_d     = 1'b1;
      default: in_ready_d = 1'b0;
    endcase
  end

  // State, operand and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ops_cnt_q  <= 8'd0;
      in_ready_q <= 1'b1;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ops_cnt_q  <= ops_cnt_d;
      in_ready_q <= in_ready_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.en       = en_q;
  assign bus.done     = done_q;
  assign bus.ops_cnt  = ops_cnt_q;

`ifdef OPLOAD_CARRY_EN
  logic carry_q, carry_d;

  // Carry is sampled alongside the adder capture and held until the next issue
  always_comb begin
    if (state_q == ISSUE) begin
      carry_d = add_carry(a_q, b_q);
    end else begin
      carry_d = carry_q;
    end
  end

  // Carry register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign bus.carry = carry_q;
`endif

endmodule

// File: tb/tb_binary_add_6_opload.sv
// Scoreboard bench for binary_add_6_opload: expected pairs are queued at B
// transfer and checked by a monitor whenever done is presented.
module tb_binary_add_6_opload;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_add_6_opload_if #(.W(6)) ifc ();
  binary_add_6_opload #(.W(6)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] s;
    logic       c;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         passes   = 0;
  int         exp_cnt  = 0;
  int         cyc      = 0;
  bit         prev_en  = 1'b0;
  bit         saw_wrap = 1'b0;
  logic [5:0] s_model  = 6'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Cycle counter and behavioural model of the downstream registered adder
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.en) s_model <= ifc.A + ifc.B;
  end

  // Monitor: pops one expectation per done and compares
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      prev_en = 1'b0;
      q.delete();
    end else begin
      if (ifc.en) check("en_single_cycle", prev_en, 0);
      if (ifc.done) begin
        check("done_after_en", prev_en, 1);
        check("ready_low_in_done", ifc.in_ready, 0);
        check("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("A_at_done", ifc.A, mon_e.a);
          check("B_at_done", ifc.B, mon_e.b);
          check("adder_S", s_model, mon_e.s);
          check("ops_cnt_at_done", ifc.ops_cnt, exp_cnt);
`ifdef OPLOAD_CARRY_EN
          check("carry", ifc.carry, mon_e.c);
`endif
          if (exp_cnt == 255 && ifc.ops_cnt == 8'd255) saw_wrap = 1'b1;
          exp_cnt = (exp_cnt + 1) % 256;
        end
      end
      prev_en = ifc.en;
    end
  end

  task automatic push_exp(input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] s, input logic c);
    exp_t e;
    e.a = a; e.b = b; e.s = s; e.c = c;
    q.push_back(e);
  endtask

  // Present a word at a negedge, wait for in_ready, return at the negedge after transfer
  task automatic send(input logic [5:0] d, input bit keep);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("xfer_timeout", n, 0);
    @(negedge clk);
    if (!keep) ifc.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    ifc.in_valid = 1'b0;
    ifc.in_data  = 6'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_A", ifc.A, 0);
    check("rst_B", ifc.B, 0);
    check("rst_ops_cnt", ifc.ops_cnt, 0);
    check("rst_en", ifc.en, 0);
    check("rst_done", ifc.done, 0);
    check("rst_in_ready", ifc.in_ready, 1);
`ifdef OPLOAD_CARRY_EN
    check("rst_carry", ifc.carry, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0;
    logic [6:0] full;
    logic [5:0] a, b;

    do_reset();

    // Abort an operation with reset while in ISSUE
    send(6'd7, 1'b1);
    send(6'd8, 1'b0);
    check("abort_en_in_issue", ifc.en, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_en_drop", ifc.en, 0);
    check("abort_A", ifc.A, 0);
    check("abort_B", ifc.B, 0);
    check("abort_ops_cnt", ifc.ops_cnt, 0);
    check("abort_in_ready", ifc.in_ready, 1);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", ifc.done, 0);

    // 5 + 9 with in_valid held across the pair
    send(6'd5, 1'b1);
    send(6'd9, 1'b0);
    push_exp(6'd5, 6'd9, 6'd14, 1'b0);
    check("latency_en", ifc.en, 1);
    check("latency_ready_low", ifc.in_ready, 0);
    @(negedge clk);
    check("latency_done", ifc.done, 1);
    @(negedge clk);
    check("ops_cnt_after_first", ifc.ops_cnt, 1);

    // Overflowing pair
    send(6'd40, 1'b0);
    send(6'd30, 1'b0);
    push_exp(6'd40, 6'd30, 6'd6, 1'b1);

    // Stall in LOAD_B
    send(6'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check("stall_in_ready", ifc.in_ready, 1);
      check("stall_A_held", ifc.A, 2);
      @(negedge clk);
    end
    send(6'd1, 1'b0);
    push_exp(6'd2, 6'd1, 6'd3, 1'b0);

    // New data offered during ISSUE/WAIT must not be consumed
    send(6'd17, 1'b1);
    send(6'd20, 1'b1);
    push_exp(6'd17, 6'd20, 6'd37, 1'b0);
    ifc.in_data = 6'd63;
    check("hold_ready_issue", ifc.in_ready, 0);
    @(negedge clk);
    check("hold_ready_wait", ifc.in_ready, 0);
    check("hold_A", ifc.A, 17);
    check("hold_B", ifc.B, 20);
    send(6'd63, 1'b1);
    check("next_A_capture", ifc.A, 63);
    send(6'd0, 1'b0);
    push_exp(6'd63, 6'd0, 6'd63, 1'b0);
    drain();

    // 256 back-to-back operations from a fresh reset
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 256; k++) begin
      a = k[5:0];
      b = 6'(k * 7);
      full = {1'b0, a} + {1'b0, b};
      send(a, 1'b1);
      send(b, (k != 255));
      push_exp(a, b, full[5:0], full[6]);
    end
    check("b2b_cycles", cyc - c0, 1022);
    drain();
    check("wrap_ops_cnt", ifc.ops_cnt, 0);
    check("wrap_seen_255", saw_wrap, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
